// File: rtl/psddivide_n.sv
// psddivide_n: parametrised sequential non-restoring divider with
// signed mode, start/busy/done handshake, abort and error flags.
module psddivide_n #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rest
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             sgn;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] rmag;

  assign sgn      = SIGNED_EN && signed_op;
  assign dvd_neg  = sgn && dividend[WIDTH-1];
  assign dvs_neg  = sgn && divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;
  assign dvs_zero = (divisor == '0);
  assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};

  // acc_q shifts dividend bits out at the top and quotient bits in
  assign shl  = {prem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign step = prem_q[WIDTH] ? shl + {1'b0, dvs_q}
                              : shl - {1'b0, dvs_q};
  assign rmag = prem_q[WIDTH] ? prem_q[WIDTH-1:0] + dvs_q
                              : prem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_d   = CW'(WIDTH-1);
          prem_d  = '0;
          dvs_d   = dvs_mag;
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
          dz_d    = dvs_zero;
          ov_d    = sgn && (dividend == min_val)
                        && (divisor == '1);
          // zero divisor keeps the raw dividend for rest
          acc_d   = dvs_zero ? dividend : dvd_mag;
          state_d = dvs_zero ? FIX : ITER;
        end
      end
      ITER: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          prem_d = step;
          acc_d  = {acc_q[WIDTH-2:0], ~step[WIDTH]};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          dbz_d  = dz_q;
          ovf_d  = ov_q;
          if (dz_q) begin
            quo_d = '1;
            rem_d = acc_q;
          end else begin
            quo_d = qneg_q ? -acc_q : acc_q;
            rem_d = rneg_q ? -rmag : rmag;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = SIGNED_EN ? ovf_q : 1'b0;
  assign quotient    = quo_q;
  assign rest        = rem_q;

endmodule

// File: tb/tb_psddivide_n.sv
// Bench for psddivide_n: 32-bit signed-capable and 8-bit
// unsigned-only instances against an arithmetic reference.
module tb_psddivide_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st32, ab32, so32;
  logic [31:0] dd32, dv32, q32, r32;
  logic        bz32, dn32, dz32, ov32;

  logic        st8, ab8, so8;
  logic [7:0]  dd8, dv8, q8, r8;
  logic        bz8, dn8, dz8, ov8;

  int checks = 0;
  int errors = 0;

  psddivide_n #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
    .clock(clk), .reset(reset), .start(st32), .abort(ab32),
    .signed_op(so32), .dividend(dd32), .divisor(dv32),
    .busy(bz32), .done(dn32), .div_by_zero(dz32),
    .overflow(ov32), .quotient(q32), .rest(r32)
  );

  psddivide_n #(.WIDTH(8), .SIGNED_EN(1'b0)) u8 (
    .clock(clk), .reset(reset), .start(st8), .abort(ab8),
    .signed_op(so8), .dividend(dd8), .divisor(dv8),
    .busy(bz8), .done(dn8), .div_by_zero(dz8),
    .overflow(ov8), .quotient(q8), .rest(r8)
  );

  // reference: plain integer division truncating toward zero
  function automatic void model(
    input  longint unsigned a,
    input  longint unsigned b,
    input  bit              s,
    input  int              w,
    output longint unsigned q,
    output longint unsigned r,
    output bit              dz,
    output bit              ov
  );
    longint unsigned m;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = m;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      q  = sa / sb;
      r  = sa % sb;
      q  = q & m;
      r  = r & m;
      ov = (a == (64'd1 << (w - 1))) && (b == m);
    end
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int lat,
                       output logic b1, output logic bp);
    @(negedge clk);
    st32 = 1'b1; ab32 = 1'b0; so32 = s; dd32 = a; dv32 = b;
    @(posedge clk); #1;
    st32 = 1'b0; dd32 = $urandom; dv32 = $urandom;
    so32 = 1'($urandom);
    lat = 1;
    b1  = bz32;
    bp  = bz32;
    while (dn32 !== 1'b1 && lat < 60) begin
      bp = bz32;
      @(posedge clk); #1;
      lat++;
    end
    if (dn32 !== 1'b1) lat = -1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, output int lat);
    @(negedge clk);
    st8 = 1'b1; ab8 = 1'b0; so8 = s; dd8 = a; dv8 = b;
    @(posedge clk); #1;
    st8 = 1'b0; dd8 = 8'($urandom); dv8 = 8'($urandom);
    lat = 1;
    while (dn8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (dn8 !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({bz32, dn32, dz32, ov32} !== 4'b0) begin
      errors++;
      $display("FAIL reset32_flags: got %b want 0000",
               {bz32, dn32, dz32, ov32});
    end
    checks++;
    if ({q32, r32} !== 64'd0) begin
      errors++;
      $display("FAIL reset32_data: got %h/%h want 0/0", q32, r32);
    end
    checks++;
    if ({bz8, dn8, dz8, ov8, q8, r8} !== 20'd0) begin
      errors++;
      $display("FAIL reset8: got %h want 0",
               {bz8, dn8, dz8, ov8, q8, r8});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    int lat;
    logic b1, bp;
    run32(32'h12345678, 32'h0BEEFEBA, 1'b0, lat, b1, bp);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 34", lat);
    end
    checks++;
    if ({b1, bp, bz32} !== 3'b110) begin
      errors++;
      $display("FAIL basic_busy: got %b want 110", {b1, bp, bz32});
    end
    checks++;
    if (q32 !== 32'h1 || r32 !== 32'h064557BE) begin
      errors++;
      $display("FAIL basic_result: got %h/%h want 1/064557be",
               q32, r32);
    end
    checks++;
    if ({dz32, ov32} !== 2'b00) begin
      errors++;
      $display("FAIL basic_flags: got %b want 00", {dz32, ov32});
    end
  endtask

  task automatic test_signed();
    int lat;
    logic b1, bp;
    run32(32'hFFFFFFF9, 32'd2, 1'b1, lat, b1, bp);
    checks++;
    if (q32 !== 32'hFFFFFFFD || r32 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL signed_m7_2: got %h/%h want fffffffd/ffffffff",
               q32, r32);
    end
    run32(32'd7, 32'hFFFFFFFE, 1'b1, lat, b1, bp);
    checks++;
    if (q32 !== 32'hFFFFFFFD || r32 !== 32'h1) begin
      errors++;
      $display("FAIL signed_7_m2: got %h/%h want fffffffd/1",
               q32, r32);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    logic b1, bp;
    for (int m = 0; m < 2; m++) begin
      run32(32'd5, 32'd0, 1'(m), lat, b1, bp);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL dbz_latency m%0d: got %0d want 2", m, lat);
      end
      checks++;
      if (q32 !== 32'hFFFFFFFF || r32 !== 32'd5
          || {dz32, ov32} !== 2'b10) begin
        errors++;
        $display("FAIL dbz_result m%0d: got %h/%h %b want ffffffff/5 10",
                 m, q32, r32, {dz32, ov32});
      end
    end
    run32(32'd10, 32'd3, 1'b0, lat, b1, bp);
    checks++;
    if (q32 !== 32'd3 || r32 !== 32'd1 || dz32 !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: got %h/%h dz=%b want 3/1 dz=0",
               q32, r32, dz32);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic b1, bp;
    run32(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, b1, bp);
    checks++;
    if (q32 !== 32'h80000000 || r32 !== 32'd0 || ov32 !== 1'b1
        || lat != 34) begin
      errors++;
      $display("FAIL ovf_signed: got %h/%h ov=%b lat=%0d want 80000000/0 1 34",
               q32, r32, ov32, lat);
    end
    run32(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, b1, bp);
    checks++;
    if (q32 !== 32'd0 || r32 !== 32'h80000000 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_unsigned: got %h/%h ov=%b want 0/80000000 0",
               q32, r32, ov32);
    end
  endtask

  task automatic test_abort();
    int lat, cyc;
    logic b1, bp;
    bit seen;
    run32(32'd10, 32'd3, 1'b0, lat, b1, bp);
    @(negedge clk);
    st32 = 1'b1; so32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7;
    @(posedge clk); #1;
    st32 = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    ab32 = 1'b1;
    @(posedge clk); #1;
    ab32 = 1'b0;
    checks++;
    if (bz32 !== 1'b0 || dn32 !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b done=%b want 0 0",
               bz32, dn32);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn32 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse want none");
    end
    checks++;
    if (q32 !== 32'd3 || r32 !== 32'd1 || {dz32, ov32} !== 2'b00) begin
      errors++;
      $display("FAIL abort_hold: got %h/%h %b want 3/1 00",
               q32, r32, {dz32, ov32});
    end
    @(negedge clk);
    st32 = 1'b1; ab32 = 1'b1; dd32 = 32'd9; dv32 = 32'd0;
    @(posedge clk); #1;
    st32 = 1'b0; ab32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bz32 !== 1'b0 || q32 !== 32'd3 || dz32 !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: got busy=%b q=%h dz=%b want 0 3 0",
               bz32, q32, dz32);
    end
  endtask

  task automatic test_reset_midway();
    int lat, cyc;
    logic b1, bp;
    run32(32'd50, 32'd0, 1'b0, lat, b1, bp);
    @(negedge clk);
    st32 = 1'b1; so32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7;
    @(posedge clk); #1;
    st32 = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bz32, dn32, dz32, ov32} !== 4'b0 || {q32, r32} !== 64'd0) begin
      errors++;
      $display("FAIL midreset: got %b %h/%h want 0000 0/0",
               {bz32, dn32, dz32, ov32}, q32, r32);
    end
    @(negedge clk);
    reset = 1'b0;
    run32(32'd100, 32'd7, 1'b0, lat, b1, bp);
    checks++;
    if (q32 !== 32'd14 || r32 !== 32'd2 || lat != 34) begin
      errors++;
      $display("FAIL after_reset: got %h/%h lat=%0d want e/2 34",
               q32, r32, lat);
    end
  endtask

  task automatic test_random32();
    int lat;
    logic b1, bp;
    logic [31:0] a, b;
    logic s;
    longint unsigned eq, er;
    bit edz, eov;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      model(a, b, s, 32, eq, er, edz, eov);
      run32(a, b, s, lat, b1, bp);
      checks++;
      if (q32 !== 32'(eq) || r32 !== 32'(er)) begin
        errors++;
        $display("FAIL rnd32 %h/%h s=%b: got %h/%h want %h/%h",
                 a, b, s, q32, r32, 32'(eq), 32'(er));
      end
      checks++;
      if ({dz32, ov32} !== {edz, eov}) begin
        errors++;
        $display("FAIL rnd32_flags %h/%h s=%b: got %b want %b",
                 a, b, s, {dz32, ov32}, {edz, eov});
      end
      checks++;
      if (lat != (b == 0 ? 2 : 34)) begin
        errors++;
        $display("FAIL rnd32_latency %h/%h: got %0d want %0d",
                 a, b, lat, (b == 0 ? 2 : 34));
      end
    end
  endtask

  task automatic test_width8();
    int lat, cyc;
    @(negedge clk);
    st8 = 1'b1; so8 = 1'b0; dd8 = 8'd200; dv8 = 8'd7;
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 1;
    while (dn8 !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      if (cyc == 5) begin
        st8 = 1'b1; dd8 = 8'd1; dv8 = 8'd1;
      end
      @(posedge clk); #1;
      st8 = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc != 10 || q8 !== 8'd28 || r8 !== 8'd4) begin
      errors++;
      $display("FAIL w8_200_7: got cyc=%0d %h/%h want 10 1c/04",
               cyc, q8, r8);
    end
    run8(8'd255, 8'd255, 1'b0, lat);
    checks++;
    if (lat != 10 || q8 !== 8'd1 || r8 !== 8'd0) begin
      errors++;
      $display("FAIL w8_start_in_done: got lat=%0d %h/%h want 10 1/0",
               lat, q8, r8);
    end
    run8(8'h80, 8'hFF, 1'b1, lat);
    checks++;
    if (q8 !== 8'd0 || r8 !== 8'h80 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_unsigned_only: got %h/%h ov=%b want 0/80 0",
               q8, r8, ov8);
    end
    run8(8'd5, 8'd0, 1'b0, lat);
    checks++;
    if (lat != 2 || q8 !== 8'hFF || r8 !== 8'd5 || dz8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_dbz: got lat=%0d %h/%h dz=%b want 2 ff/05 1",
               lat, q8, r8, dz8);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] a, b;
    longint unsigned eq, er;
    bit edz, eov;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, 1'b0, 8, eq, er, edz, eov);
      run8(a, b, 1'($urandom), lat);
      checks++;
      if (q8 !== 8'(eq) || r8 !== 8'(er)
          || {dz8, ov8} !== {edz, 1'b0}) begin
        errors++;
        $display("FAIL b2b8 %h/%h: got %h/%h %b want %h/%h %b",
                 a, b, q8, r8, {dz8, ov8}, 8'(eq), 8'(er), {edz, 1'b0});
      end
      checks++;
      if (lat != (b == 0 ? 2 : 10)) begin
        errors++;
        $display("FAIL b2b8_latency %h/%h: got %0d want %0d",
                 a, b, lat, (b == 0 ? 2 : 10));
      end
    end
  endtask

  initial begin
    st32 = 1'b0; ab32 = 1'b0; so32 = 1'b0; dd32 = '0; dv32 = '0;
    st8  = 1'b0; ab8  = 1'b0; so8  = 1'b0; dd8  = '0; dv8  = '0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_abort();
    test_reset_midway();
    test_random32();
    test_width8();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
